// File: rtl/kernel_exec_profiler_pkg.sv
// Shared types for the kernel execution profiler.
// Build option: KEP_ACCUMULATE_EN (accumulate across runs).
package kernel_exec_profiler_pkg;

  typedef enum logic [1:0] {
    PROFILE,
    FREEZE,
    REPORT,
    DONE
  } kep_state_e;

  localparam int unsigned KepRunsW   = 8;
  localparam int unsigned KepFlagsW  = 3;
  localparam int unsigned KepChW     = 8;
  localparam int unsigned KepCntMaxW = 64;

  localparam int unsigned FlagInc   = 0;
  localparam int unsigned FlagSat   = 1;
  localparam int unsigned FlagMulti = 2;

  // Widest-case record; the top trims fields to its parameters.
  typedef struct packed {
    logic [KepChW-1:0]     ch;
    logic [KepCntMaxW-1:0] cycles;
    logic [KepRunsW-1:0]   runs;
    logic [KepFlagsW-1:0]  flags;
  } kep_rpt_t;

endpackage

// File: rtl/kernel_exec_profiler_ch.sv
// One profiled channel: edge detect, saturating cycle/run counters, flags.
// Build option: KEP_ACCUMULATE_EN keeps the count across rises.
module kernel_exec_profiler_ch
  import kernel_exec_profiler_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TAIL_CYCLES = 5,
  parameter int unsigned CH_IDX      = 0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     busy_i,
  input  logic     freeze_i,
  input  logic     snap_i,
  output kep_rpt_t rpt_o
);

`ifdef KEP_ACCUMULATE_EN
  localparam bit Accum = 1'b1;
`else
  localparam bit Accum = 1'b0;
`endif

  localparam logic [CNT_W:0] OneAdd  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] TailAdd = (CNT_W+1)'(TAIL_CYCLES);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    base;
  logic [CNT_W:0]      sum;
  logic [KepRunsW-1:0] runs_q, runs_d;
  logic                sat_q, sat_d;
  logic                inc_q, inc_d;
  logic                rise, fall;

  assign rise = busy_i & ~busy_q;
  assign fall = ~busy_i & busy_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    runs_d = runs_q;
    sat_d  = sat_q;
    inc_d  = inc_q;
    base   = (rise && !Accum) ? '0 : cnt_q;
    sum    = {1'b0, base} + (busy_i ? OneAdd : TailAdd);
    if (!freeze_i) begin
      busy_d = busy_i;
      if (busy_i || fall) begin
        if (sum[CNT_W]) begin
          cnt_d = '1;
          sat_d = 1'b1;
        end else begin
          cnt_d = sum[CNT_W-1:0];
        end
      end
      if (fall && runs_q != '1) begin
        runs_d = runs_q + KepRunsW'(1);
      end
    end
    if (snap_i) begin
      inc_d = busy_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      runs_q <= '0;
      sat_q  <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      runs_q <= runs_d;
      sat_q  <= sat_d;
      inc_q  <= inc_d;
    end
  end

  always_comb begin
    rpt_o                  = '0;
    rpt_o.ch               = KepChW'(CH_IDX);
    rpt_o.cycles           = KepCntMaxW'(cnt_q);
    rpt_o.runs             = runs_q;
    rpt_o.flags[FlagInc]   = inc_q;
    rpt_o.flags[FlagSat]   = sat_q;
    rpt_o.flags[FlagMulti] = (runs_q >= KepRunsW'(2));
  end

endmodule

// File: rtl/kernel_exec_profiler.sv
// Kernel execution profiler: per-channel counters plus freeze/report FSM.
// Build option: KEP_ACCUMULATE_EN (sum all runs instead of last run).
module kernel_exec_profiler
  import kernel_exec_profiler_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TAIL_CYCLES = 5,
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_CH-1:0]   busy_i,
  input  logic                exit_valid_i,
  output logic                rpt_valid_o,
  input  logic                rpt_ready_i,
  output logic [IdxW-1:0]     rpt_ch_o,
  output logic [CNT_W-1:0]    rpt_cycles_o,
  output logic [KepRunsW-1:0] rpt_runs_o,
  output logic [2:0]          rpt_flags_o,
  output logic                done_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);

  kep_state_e      state_q;
  logic [IdxW-1:0] idx_q;
  logic            valid_q;
  logic            done_q;
  logic            freeze;
  logic            snap;
  kep_rpt_t        rec [NUM_CH];
  kep_rpt_t        cur;
  logic            unused_cur;

  assign freeze = (state_q != PROFILE);
  assign snap   = (state_q == FREEZE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    kernel_exec_profiler_ch #(
      .CNT_W      (CNT_W),
      .TAIL_CYCLES(TAIL_CYCLES),
      .CH_IDX     (g)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .busy_i  (busy_i[g]),
      .freeze_i(freeze),
      .snap_i  (snap),
      .rpt_o   (rec[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PROFILE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        PROFILE: begin
          if (exit_valid_i) state_q <= FREEZE;
        end
        FREEZE: begin
          state_q <= REPORT;
          idx_q   <= '0;
          valid_q <= 1'b1;
        end
        REPORT: begin
          if (rpt_ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= PROFILE;
      endcase
    end
  end

  assign cur        = rec[idx_q];
  assign unused_cur = ^cur;

  // Payload is gated so idle outputs read zero, including under reset.
  assign rpt_valid_o  = valid_q;
  assign rpt_ch_o     = valid_q ? cur.ch[IdxW-1:0] : '0;
  assign rpt_cycles_o = valid_q ? cur.cycles[CNT_W-1:0] : '0;
  assign rpt_runs_o   = valid_q ? cur.runs : '0;
  assign rpt_flags_o  = valid_q ? cur.flags : '0;
  assign done_o       = done_q;

endmodule

// File: tb/tb_kernel_exec_profiler.sv
// Directed bench for kernel_exec_profiler: vector table plus corner sequences.
// Covers both KEP_ACCUMULATE_EN settings via expected-value selection.
module tb_kernel_exec_profiler;

`ifdef KEP_ACCUMULATE_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  busy = '0;
  logic        exit_v = 1'b0;
  logic        ready = 1'b1;

  logic        valid, done;
  logic [0:0]  ch;
  logic [31:0] cyc;
  logic [7:0]  runs;
  logic [2:0]  flags;

  logic        s_valid, s_done;
  logic [0:0]  s_ch;
  logic [3:0]  s_cyc;
  logic [7:0]  s_runs;
  logic [2:0]  s_flags;

  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  kernel_exec_profiler #(
    .NUM_CH(2), .CNT_W(32), .TAIL_CYCLES(5)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy),
    .exit_valid_i(exit_v), .rpt_valid_o(valid),
    .rpt_ready_i(ready), .rpt_ch_o(ch),
    .rpt_cycles_o(cyc), .rpt_runs_o(runs),
    .rpt_flags_o(flags), .done_o(done)
  );

  kernel_exec_profiler #(
    .NUM_CH(2), .CNT_W(4), .TAIL_CYCLES(5)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .busy_i(busy),
    .exit_valid_i(exit_v), .rpt_valid_o(s_valid),
    .rpt_ready_i(ready), .rpt_ch_o(s_ch),
    .rpt_cycles_o(s_cyc), .rpt_runs_o(s_runs),
    .rpt_flags_o(s_flags), .done_o(s_done)
  );

  typedef struct {
    string       name;
    int          p0a, p0b, p1, open1;
    int unsigned cyc0, cyc1;
    int          runs0, runs1;
    logic [2:0]  fl0, fl1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    busy   = '0;
    exit_v = 1'b0;
    ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input int c, input int n);
    busy[c] = 1'b1;
    repeat (n) tick();
    busy[c] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic fire_exit();
    exit_v = 1'b1;
    tick();
    exit_v = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned ec;
    int er;
    logic [2:0] ef;
    do_reset();
    if (v.p0a > 0) pulse(0, v.p0a);
    if (v.p0b > 0) pulse(0, v.p0b);
    if (v.p1 > 0) pulse(1, v.p1);
    if (v.open1 > 0) begin
      busy[1] = 1'b1;
      repeat (v.open1 - 1) tick();
      fire_exit();
    end else begin
      repeat (5) tick();
      fire_exit();
    end
    chk({v.name, " valid_in_freeze"}, valid, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      ec = (k == 0) ? v.cyc0 : v.cyc1;
      er = (k == 0) ? v.runs0 : v.runs1;
      ef = (k == 0) ? v.fl0 : v.fl1;
      chk({v.name, " valid"}, valid, 1);
      chk({v.name, " ch"}, ch, k);
      chk({v.name, " cycles"}, cyc, ec);
      chk({v.name, " runs"}, runs, er);
      chk({v.name, " flags"}, flags, ef);
      chk({v.name, " done_early"}, done, 0);
      tick();
    end
    chk({v.name, " done"}, done, 1);
    chk({v.name, " valid_after"}, valid, 0);
  endtask

  initial begin
    int xf;
    vecs[0] = '{"single", 0, 0, 100, 0, 0, 105, 0, 1, 3'b000, 3'b000};
    vecs[1] = '{"tworun", 20, 30, 0, 0, ACC ? 60 : 35, 0, 2, 0,
                3'b100, 3'b000};
    vecs[2] = '{"open7", 3, 0, 0, 7, 8, 7, 1, 0, 3'b000, 3'b001};
    vecs[3] = '{"short", 1, 0, 2, 0, 6, 7, 1, 1, 3'b000, 3'b000};
    vecs[4] = '{"rise_exit", 0, 0, 0, 1, 0, 1, 0, 0, 3'b000, 3'b001};

    rst_n = 1'b0;
    #3;
    chk("rst valid", valid, 0);
    chk("rst done", done, 0);
    chk("rst cycles", cyc, 0);
    chk("rst flags", flags, 0);
    do_reset();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Fall coincides with exit: tail added, not incomplete.
    do_reset();
    busy[0] = 1'b1;
    repeat (4) tick();
    busy[0] = 1'b0;
    fire_exit();
    tick();
    chk("fallexit valid", valid, 1);
    chk("fallexit cycles", cyc, 9);
    chk("fallexit runs", runs, 1);
    chk("fallexit flags", flags, 3'b000);

    // Backpressure with a stray second exit.
    do_reset();
    ready = 1'b0;
    pulse(0, 3);
    fire_exit();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", valid, 1);
      chk("bp cycles", cyc, 8);
      chk("bp ch", ch, 0);
      exit_v = (i == 2);
      tick();
    end
    exit_v = 1'b0;
    ready = 1'b1;
    xf = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (valid && ready) xf++;
      tick();
    end
    chk("bp transfers", xf, 2);
    chk("bp done", done, 1);
    repeat (3) tick();
    chk("bp done_sticky", done, 1);
    chk("bp valid_low", valid, 0);

    // Saturation on the 4-bit instance.
    do_reset();
    pulse(0, 20);
    fire_exit();
    tick();
    chk("sat wide cycles", cyc, 25);
    chk("sat wide flags", flags, 3'b000);
    chk("sat valid", s_valid, 1);
    chk("sat cycles", s_cyc, 15);
    chk("sat flags", s_flags, 3'b010);
    chk("sat runs", s_runs, 1);

    // Runs counter saturates at 255.
    do_reset();
    repeat (256) begin
      busy[0] = 1'b1;
      tick();
      busy[0] = 1'b0;
      tick();
    end
    repeat (3) tick();
    fire_exit();
    tick();
    chk("runsat runs", runs, 255);
    chk("runsat flags", flags, 3'b100);
    chk("runsat cycles", cyc, ACC ? 1536 : 6);

    // Asynchronous reset in the middle of a stalled report.
    do_reset();
    ready = 1'b0;
    pulse(0, 6);
    fire_exit();
    tick();
    chk("rstmid valid_pre", valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid valid", valid, 0);
    chk("rstmid cycles", cyc, 0);
    chk("rstmid runs", runs, 0);
    chk("rstmid flags", flags, 0);
    chk("rstmid done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    pulse(0, 10);
    fire_exit();
    chk("rstmid re_freeze", valid, 0);
    tick();
    chk("rstmid re_valid", valid, 1);
    chk("rstmid re_cycles", cyc, 15);
    chk("rstmid re_runs", runs, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
